// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared types and constants for the hazard/forwarding controller of the 5-stage MIPS pipeline.
// Latency: n/a (package only); backpressure: n/a.
package hazard_fwd_ctrl_pkg;

  localparam int NREG_W = 5;
  localparam logic [NREG_W-1:0] LINK_REG = 5'd31;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_W     = 2'd1;
  localparam logic [1:0] FWD_M_ALU = 2'd2;
  localparam logic [1:0] FWD_M_PC8 = 2'd3;

  typedef logic [NREG_W-1:0] reg_addr_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t wr_addr;
    logic      wr_en;
    logic      mem_to_reg;
    logic      jump_link;
  } stage_t;

  // Register 0 is hardwired, so it never produces a hazard.
  function automatic logic writes(input stage_t s, input reg_addr_t r);
    return s.valid & s.wr_en & (s.wr_addr == r) & (r != '0);
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_select.sv
// Forward-source select for one source register against the M and W shadow records.
// Latency: combinational; backpressure: none (pure compare/priority, M beats W).
module hazard_fwd_ctrl_fwd_select
  import hazard_fwd_ctrl_pkg::*;
(
  input  reg_addr_t  src,
  input  stage_t     m_stage,
  input  stage_t     w_stage,
  output logic [1:0] sel
);

  // W data is final write-back data, so its load/link flags do not affect the select.
  logic unused_w_flags;
  assign unused_w_flags = w_stage.mem_to_reg ^ w_stage.jump_link;

  always_comb begin
    sel = FWD_RF;
    if (writes(m_stage, src) && !m_stage.mem_to_reg) begin
      sel = m_stage.jump_link ? FWD_M_PC8 : FWD_M_ALU;
    end else if (writes(w_stage, src)) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding control with a shadow E/M/W pipeline: forwarding selects, PC/D stall, E bubble, next-PC select.
// Latency: outputs combinational from shadow state + D inputs; backpressure: stall_fd holds PC and IF/ID.
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREG_W-1:0] d_rs,
  input  logic [NREG_W-1:0] d_rt,
  input  logic              d_use_rs_d,
  input  logic              d_use_rt_d,
  input  logic [NREG_W-1:0] d_wr_addr,
  input  logic              d_wr_en,
  input  logic              d_mem_to_reg,
  input  logic              d_jump_link,
  input  logic              d_redirect,
  output logic              stall_fd,
  output logic              bubble_e,
  output logic              npc_sel,
  output logic [1:0]        fwd_d_a,
  output logic [1:0]        fwd_d_b,
  output logic [1:0]        fwd_e_a,
  output logic [1:0]        fwd_e_b,
  output logic              m_fwd_link
);

  stage_t    e_q, e_d, m_q, m_d, w_q, w_d;
  reg_addr_t e_rs_q, e_rs_d, e_rt_q, e_rt_d;

  logic load_use, br_e_hit, br_m_hit;

  always_comb begin
    // Loads stall on any rs/rt match, whether D really needs that operand or not.
    load_use = e_q.mem_to_reg & (writes(e_q, d_rs) | writes(e_q, d_rt));
    br_e_hit = (d_use_rs_d & writes(e_q, d_rs)) | (d_use_rt_d & writes(e_q, d_rt));
    br_m_hit = m_q.mem_to_reg &
               ((d_use_rs_d & writes(m_q, d_rs)) | (d_use_rt_d & writes(m_q, d_rt)));
    stall_fd   = load_use | br_e_hit | br_m_hit;
    bubble_e   = stall_fd;
    npc_sel    = d_redirect & ~stall_fd;
    m_fwd_link = m_q.valid & m_q.jump_link;
  end

  always_comb begin
    e_d    = '0;
    e_rs_d = '0;
    e_rt_d = '0;
    m_d    = e_q;
    w_d    = m_q;
    if (!bubble_e) begin
      e_d.valid      = 1'b1;
      e_d.wr_addr    = d_wr_addr;
      e_d.wr_en      = d_wr_en;
      e_d.mem_to_reg = d_mem_to_reg;
      e_d.jump_link  = d_jump_link;
      e_rs_d         = d_rs;
      e_rt_d         = d_rt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q    <= '0;
      m_q    <= '0;
      w_q    <= '0;
      e_rs_q <= '0;
      e_rt_q <= '0;
    end else begin
      e_q    <= e_d;
      m_q    <= m_d;
      w_q    <= w_d;
      e_rs_q <= e_rs_d;
      e_rt_q <= e_rt_d;
    end
  end

  hazard_fwd_ctrl_fwd_select u_fwd_d_a (.src(d_rs),   .m_stage(m_q), .w_stage(w_q), .sel(fwd_d_a));
  hazard_fwd_ctrl_fwd_select u_fwd_d_b (.src(d_rt),   .m_stage(m_q), .w_stage(w_q), .sel(fwd_d_b));
  hazard_fwd_ctrl_fwd_select u_fwd_e_a (.src(e_rs_q), .m_stage(m_q), .w_stage(w_q), .sel(fwd_e_a));
  hazard_fwd_ctrl_fwd_select u_fwd_e_b (.src(e_rt_q), .m_stage(m_q), .w_stage(w_q), .sel(fwd_e_b));

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: expectations queued per cycle, popped and compared at the falling edge.
module tb_hazard_fwd_ctrl;
  import hazard_fwd_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] d_rs = '0, d_rt = '0, d_wr_addr = '0;
  logic       d_use_rs_d = 1'b0, d_use_rt_d = 1'b0, d_wr_en = 1'b0;
  logic       d_mem_to_reg = 1'b0, d_jump_link = 1'b0, d_redirect = 1'b0;
  logic       stall_fd, bubble_e, npc_sel, m_fwd_link;
  logic [1:0] fwd_d_a, fwd_d_b, fwd_e_a, fwd_e_b;

  int checks = 0;
  int failures = 0;

  localparam int S_STALL = 0, S_BUBBLE = 1, S_NPC = 2, S_FDA = 3, S_FDB = 4,
                 S_FEA = 5, S_FEB = 6, S_LINK = 7;

  typedef struct {
    string      tag;
    int         sig;
    logic [1:0] val;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  hazard_fwd_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .d_rs(d_rs), .d_rt(d_rt), .d_use_rs_d(d_use_rs_d), .d_use_rt_d(d_use_rt_d),
    .d_wr_addr(d_wr_addr), .d_wr_en(d_wr_en), .d_mem_to_reg(d_mem_to_reg),
    .d_jump_link(d_jump_link), .d_redirect(d_redirect),
    .stall_fd(stall_fd), .bubble_e(bubble_e), .npc_sel(npc_sel),
    .fwd_d_a(fwd_d_a), .fwd_d_b(fwd_d_b), .fwd_e_a(fwd_e_a), .fwd_e_b(fwd_e_b),
    .m_fwd_link(m_fwd_link)
  );

  function automatic logic [1:0] obs(input int sig);
    case (sig)
      S_STALL:  return {1'b0, stall_fd};
      S_BUBBLE: return {1'b0, bubble_e};
      S_NPC:    return {1'b0, npc_sel};
      S_FDA:    return fwd_d_a;
      S_FDB:    return fwd_d_b;
      S_FEA:    return fwd_e_a;
      S_FEB:    return fwd_e_b;
      default:  return {1'b0, m_fwd_link};
    endcase
  endfunction

  task automatic ex(input string tag, input int sig, input logic [1:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic ex_idle(input string tag);
    for (int i = 0; i < 8; i++) ex($sformatf("%s_%0d", tag, i), i, 2'd0);
  endtask

  task automatic check_now();
    exp_t e;
    logic [1:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.sig);
      checks++;
      assert (o === e.val) else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, o, e.val);
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    check_now();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                     input logic urt, input logic [4:0] wa, input logic we,
                     input logic ld, input logic jl, input logic rd);
    d_rs = rs; d_rt = rt; d_use_rs_d = urs; d_use_rt_d = urt;
    d_wr_addr = wa; d_wr_en = we; d_mem_to_reg = ld; d_jump_link = jl; d_redirect = rd;
  endtask

  task automatic nop();
    drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic flush();
    nop();
    for (int i = 0; i < 3; i++) cyc();
  endtask

  initial begin
    // Reset state
    #12;
    ex_idle("reset");
    check_now();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ALU chain, back-to-back: M ALUOut forward
    drv(5'd1, 5'd2, 0, 0, 5'd3, 1, 0, 0, 0);           // add $3
    ex("alu_add_stall", S_STALL, 2'd0);
    cyc();
    drv(5'd3, 5'd4, 0, 0, 5'd6, 1, 0, 0, 0);           // sub $6,$3,$4
    ex("alu_sub_stall", S_STALL, 2'd0);
    ex("alu_sub_fdd", S_FDA, 2'd0);
    cyc();
    nop();
    ex("alu_fwd_m", S_FEA, 2'd2);
    ex("alu_fwd_m_b", S_FEB, 2'd0);
    cyc();
    flush();

    // ALU chain with a nop between: W forward
    drv(5'd1, 5'd2, 0, 0, 5'd3, 1, 0, 0, 0);
    cyc();
    nop();
    cyc();
    drv(5'd3, 5'd4, 0, 0, 5'd6, 1, 0, 0, 0);
    cyc();
    nop();
    ex("alu_fwd_w", S_FEA, 2'd1);
    cyc();
    flush();

    // Load-use: exactly one stall cycle, then W forward
    drv(5'd1, 5'd0, 0, 0, 5'd5, 1, 1, 0, 0);           // lw $5
    cyc();
    drv(5'd5, 5'd2, 0, 0, 5'd6, 1, 0, 0, 0);           // add $6,$5,$2
    ex("lu_stall1", S_STALL, 2'd1);
    ex("lu_bubble1", S_BUBBLE, 2'd1);
    cyc();
    ex("lu_stall2", S_STALL, 2'd0);
    ex("lu_bubble2", S_BUBBLE, 2'd0);
    cyc();
    nop();
    ex("lu_fwd_w", S_FEA, 2'd1);
    cyc();
    flush();

    // Branch after load: two stall cycles, redirect on the third
    drv(5'd1, 5'd0, 0, 0, 5'd4, 1, 1, 0, 0);           // lw $4
    cyc();
    drv(5'd4, 5'd0, 1, 0, 5'd0, 0, 0, 0, 1);           // beq $4,$0 taken
    ex("bl_stall1", S_STALL, 2'd1);
    ex("bl_npc1", S_NPC, 2'd0);
    cyc();
    ex("bl_stall2", S_STALL, 2'd1);
    ex("bl_npc2", S_NPC, 2'd0);
    ex("bl_fda2", S_FDA, 2'd0);
    cyc();
    ex("bl_stall3", S_STALL, 2'd0);
    ex("bl_npc3", S_NPC, 2'd1);
    ex("bl_fda3", S_FDA, 2'd1);
    cyc();
    flush();

    // jal then add using the link register: PC+8 forward
    drv(5'd0, 5'd0, 0, 0, LINK_REG, 1, 0, 1, 1);        // jal
    ex("jal_npc", S_NPC, 2'd1);
    cyc();
    drv(5'd31, 5'd0, 0, 0, 5'd8, 1, 0, 0, 0);          // add $8,$31,$0
    ex("jal_add_stall", S_STALL, 2'd0);
    cyc();
    nop();
    ex("jal_fwd_pc8", S_FEA, 2'd3);
    ex("jal_mlink", S_LINK, 2'd1);
    cyc();
    ex("jal_mlink_gone", S_LINK, 2'd0);
    cyc();
    flush();

    // Same sequence with destination $0: never forwarded, never stalls
    drv(5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 1, 0);
    cyc();
    drv(5'd0, 5'd0, 1, 1, 5'd8, 1, 0, 0, 0);
    ex("r0_stall", S_STALL, 2'd0);
    cyc();
    nop();
    ex("r0_fwd", S_FEA, 2'd0);
    ex("r0_mlink", S_LINK, 2'd1);
    cyc();
    flush();

    // Branch in D right behind jal on $31: one stall, then D-stage PC+8 forward
    drv(5'd0, 5'd0, 0, 0, LINK_REG, 1, 0, 1, 0);
    cyc();
    drv(5'd31, 5'd0, 1, 0, 5'd0, 0, 0, 0, 1);          // jr $31
    ex("jr_stall1", S_STALL, 2'd1);
    ex("jr_npc1", S_NPC, 2'd0);
    cyc();
    ex("jr_stall2", S_STALL, 2'd0);
    ex("jr_npc2", S_NPC, 2'd1);
    ex("jr_fda", S_FDA, 2'd3);
    cyc();
    flush();

    // Double writer: M beats W, in both E and D stages
    drv(5'd1, 5'd2, 0, 0, 5'd7, 1, 0, 0, 0);           // add $7
    cyc();
    drv(5'd1, 5'd2, 0, 0, 5'd7, 1, 0, 0, 0);           // or $7
    cyc();
    drv(5'd7, 5'd7, 0, 0, 5'd9, 1, 0, 0, 0);           // sub $9,$7,$7
    cyc();
    nop();
    ex("dw_fea", S_FEA, 2'd2);
    ex("dw_feb", S_FEB, 2'd2);
    cyc();
    flush();
    drv(5'd1, 5'd2, 0, 0, 5'd7, 1, 0, 0, 0);
    cyc();
    drv(5'd1, 5'd2, 0, 0, 5'd7, 1, 0, 0, 0);
    cyc();
    nop();
    cyc();
    drv(5'd7, 5'd7, 1, 1, 5'd0, 0, 0, 0, 0);           // beq $7,$7 not taken
    ex("dw_fda", S_FDA, 2'd2);
    ex("dw_fdb", S_FDB, 2'd2);
    ex("dw_dstall", S_STALL, 2'd0);
    cyc();
    flush();

    // Reset mid-stall
    drv(5'd1, 5'd0, 0, 0, 5'd8, 1, 1, 0, 0);           // lw $8
    cyc();
    drv(5'd8, 5'd0, 0, 0, 5'd9, 1, 0, 0, 0);           // add $9,$8,$0
    @(negedge clk);
    ex("mid_stall", S_STALL, 2'd1);
    check_now();
    #1 rst_n = 1'b0;
    #1;
    ex_idle("mid_rst");
    check_now();
    #1 rst_n = 1'b1;
    #1;
    ex("post_rst_stall", S_STALL, 2'd0);
    ex("post_rst_bubble", S_BUBBLE, 2'd0);
    ex("post_rst_fea", S_FEA, 2'd0);
    ex("post_rst_mlink", S_LINK, 2'd0);
    check_now();
    @(posedge clk);
    #1;
    flush();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
